packet_gen_sequencer: RTL and testbench

Scheduler that drives one packet generator through a programmed list of traffic bursts. Each table entry holds a packet count, packet length, idle-cycle spacing and initial data value. On a run request the block loads each entry onto the generator's configuration inputs, pulses the generator's start, and waits for the generator's busy to drop. It repeats the list a programmable number of times, so long soak and mixed-size tests of the 100GbE/DCMAC datapath need no software intervention between bursts.

---
 rtl/packet_gen_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_packet_gen_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_gen_sequencer.sv
// packet_gen_sequencer: walks a programmed table of traffic bursts, loading
// each entry onto a packet generator's configuration inputs, pulsing its start
// and waiting for it to go idle, repeating the table a programmable number of
// passes (or forever) until the pass count is met or an abort is requested.
module packet_gen_sequencer #(
  parameter int ENTRIES = 8,
  parameter int AW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          tbl_wr,
  input  logic [AW-1:0] tbl_addr,
  input  logic [79:0]   tbl_wdata,
  input  logic [AW:0]   num_entries,
  input  logic [15:0]   loops,
  input  logic [15:0]   burst_gap,
  input  logic          run,
  input  logic          abort,
  output logic [31:0]   gen_packet_count,
  output logic [15:0]   gen_packet_length,
  output logic [15:0]   gen_idle_cycles,
  output logic [15:0]   gen_initial_value,
  output logic          gen_start,
  input  logic          gen_busy,
  output logic          running,
  output logic [AW-1:0] cur_entry,
  output logic [15:0]   cur_loop,
  output logic [31:0]   bursts_done,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // Burst table: {initial_value, idle_cycles, packet_length, packet_count}
  logic [79:0] burst_tbl_r [ENTRIES];

  state_t        state_r;
  state_t        state_s;
  logic [AW:0]   num_r;
  logic [15:0]   loops_r;
  logic [15:0]   gap_r;
  logic [15:0]   gap_cnt_r;
  logic [15:0]   gap_cnt_s;
  logic          abort_pend_r;
  logic [AW-1:0] cur_entry_r;
  logic [AW-1:0] cur_entry_s;
  logic [15:0]   cur_loop_r;
  logic [15:0]   cur_loop_s;
  logic [31:0]   bursts_done_r;
  logic [31:0]   gen_count_r;
  logic [15:0]   gen_len_r;
  logic [15:0]   gen_idle_r;
  logic [15:0]   gen_init_r;
  logic          gen_start_r;
  logic          running_r;
  logic          done_r;

  logic [79:0]   entry_s;
  logic [AW:0]   next_entry_s;
  logic [15:0]   next_loop_s;
  logic          abort_any_s;
  logic          start_run_s;
  logic          empty_run_s;
  logic          burst_inc_s;
  logic          advance_s;
  logic          finish_s;

  assign entry_s      = burst_tbl_r[cur_entry_r];
  assign next_entry_s = {1'b0, cur_entry_r} + {{AW{1'b0}}, 1'b1};
  assign next_loop_s  = cur_loop_r + 16'd1;
  // An abort seen this cycle counts the same as one already pending.
  assign abort_any_s  = abort_pend_r | abort;

  // Table write port; programming is only accepted while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (tbl_wr && (state_r == S_IDLE)) begin
      burst_tbl_r[tbl_addr] <= tbl_wdata;
    end
  end

  // Next-state, entry/pass bookkeeping and the shared advance step.
  always_comb begin
    state_s     = state_r;
    cur_entry_s = cur_entry_r;
    cur_loop_s  = cur_loop_r;
    gap_cnt_s   = gap_cnt_r;
    start_run_s = 1'b0;
    empty_run_s = 1'b0;
    burst_inc_s = 1'b0;
    advance_s   = 1'b0;
    finish_s    = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (run) begin
          if (num_entries != {(AW+1){1'b0}}) begin
            start_run_s = 1'b1;
            cur_entry_s = {AW{1'b0}};
            cur_loop_s  = 16'd0;
            state_s     = S_LOAD;
          end else begin
            empty_run_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort_any_s) begin
          finish_s = 1'b1;
        end else if (entry_s[31:0] == 32'd0) begin
          advance_s = 1'b1;
        end else begin
          state_s = S_START;
        end
      end
      S_START: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (!gen_busy) begin
          burst_inc_s = 1'b1;
          if (gap_r != 16'd0) begin
            gap_cnt_s = gap_r - 16'd1;
            state_s   = S_GAP;
          end else begin
            advance_s = 1'b1;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_GAP: begin
        if (abort_any_s) begin
          finish_s = 1'b1;
        end else if (gap_cnt_r == 16'd0) begin
          advance_s = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r - 16'd1;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (advance_s) begin
      if (abort_any_s) begin
        finish_s = 1'b1;
      end else if (next_entry_s < num_r) begin
        cur_entry_s = next_entry_s[AW-1:0];
        state_s     = S_LOAD;
      end else begin
        cur_loop_s = next_loop_s;
        if ((loops_r != 16'd0) && (next_loop_s == loops_r)) begin
          finish_s = 1'b1;
        end else begin
          cur_entry_s = {AW{1'b0}};
          state_s     = S_LOAD;
        end
      end
    end else begin
      cur_loop_s = cur_loop_s;
    end

    if (finish_s) begin
      state_s = S_IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // State register plus run parameters captured when a run starts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= S_IDLE;
      cur_entry_r  <= {AW{1'b0}};
      cur_loop_r   <= 16'd0;
      gap_cnt_r    <= 16'd0;
      num_r        <= {(AW+1){1'b0}};
      loops_r      <= 16'd0;
      gap_r        <= 16'd0;
      abort_pend_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_entry_r <= cur_entry_s;
      cur_loop_r  <= cur_loop_s;
      gap_cnt_r   <= gap_cnt_s;
      if (start_run_s) begin
        num_r   <= num_entries;
        loops_r <= loops;
        gap_r   <= burst_gap;
      end
      // Abort is remembered until the run winds down to idle.
      if (state_r == S_IDLE) begin
        abort_pend_r <= 1'b0;
      end else if (abort) begin
        abort_pend_r <= 1'b1;
      end
    end
  end

  // Registered generator interface and status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gen_count_r   <= 32'd0;
      gen_len_r     <= 16'd0;
      gen_idle_r    <= 16'd0;
      gen_init_r    <= 16'd0;
      gen_start_r   <= 1'b0;
      running_r     <= 1'b0;
      done_r        <= 1'b0;
      bursts_done_r <= 32'd0;
    end else begin
      // Config is captured while in LOAD and held until the next LOAD.
      if (state_r == S_LOAD) begin
        gen_count_r <= entry_s[31:0];
        gen_len_r   <= entry_s[47:32];
        gen_idle_r  <= entry_s[63:48];
        gen_init_r  <= entry_s[79:64];
      end
      gen_start_r <= (state_s == S_START);
      running_r   <= (state_s != S_IDLE);
      done_r      <= finish_s | empty_run_s;
      if (burst_inc_s) begin
        bursts_done_r <= bursts_done_r + 32'd1;
      end
    end
  end

  assign gen_packet_count  = gen_count_r;
  assign gen_packet_length = gen_len_r;
  assign gen_idle_cycles   = gen_idle_r;
  assign gen_initial_value = gen_init_r;
  assign gen_start         = gen_start_r;
  assign running           = running_r;
  assign cur_entry         = cur_entry_r;
  assign cur_loop          = cur_loop_r;
  assign bursts_done       = bursts_done_r;
  assign done              = done_r;

endmodule

// File: tb/tb_packet_gen_sequencer.sv
// Bench for packet_gen_sequencer: a small generator model answers gen_start
// with a busy window; expected bursts and run completions are queued as each
// run is launched and checked as gen_start / done appear.
module tb_packet_gen_sequencer;
  localparam int ENTRIES = 8;
  localparam int AW      = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          tbl_wr;
  logic [AW-1:0] tbl_addr;
  logic [79:0]   tbl_wdata;
  logic [AW:0]   num_entries;
  logic [15:0]   loops;
  logic [15:0]   burst_gap;
  logic          run;
  logic          abort;
  logic [31:0]   gen_packet_count;
  logic [15:0]   gen_packet_length;
  logic [15:0]   gen_idle_cycles;
  logic [15:0]   gen_initial_value;
  logic          gen_start;
  logic          gen_busy;
  logic          running;
  logic [AW-1:0] cur_entry;
  logic [15:0]   cur_loop;
  logic [31:0]   bursts_done;
  logic          done;

  always #5 clk = ~clk;

  packet_gen_sequencer #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .resetn(resetn), .tbl_wr(tbl_wr), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .num_entries(num_entries), .loops(loops),
    .burst_gap(burst_gap), .run(run), .abort(abort),
    .gen_packet_count(gen_packet_count), .gen_packet_length(gen_packet_length),
    .gen_idle_cycles(gen_idle_cycles), .gen_initial_value(gen_initial_value),
    .gen_start(gen_start), .gen_busy(gen_busy), .running(running),
    .cur_entry(cur_entry), .cur_loop(cur_loop), .bursts_done(bursts_done),
    .done(done)
  );

  // Generator model: busy for packet_count cycles after each start.
  logic [7:0] busy_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) busy_cnt <= 8'd0;
    else if (gen_start) busy_cnt <= gen_packet_count[7:0];
    else if (busy_cnt != 8'd0) busy_cnt <= busy_cnt - 8'd1;
  end
  assign gen_busy = gen_start | (busy_cnt != 8'd0);

  typedef struct {
    int          entry;
    logic [31:0] count;
    logic [15:0] len;
    logic [15:0] idle;
    logic [15:0] init;
    bit          from_run;
    int          delay;
  } start_t;

  typedef struct {
    logic [31:0] bursts;
    int          loop;
    bit          from_run;
    int          delay;
  } done_t;

  start_t      exp_start[$];
  done_t       exp_done[$];
  logic [79:0] tbl_m [ENTRIES];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          run_cyc = 0;
  int          fall_cyc = 0;
  int          done_cnt = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] exp_bursts = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops scoreboard entries on gen_start and done.
  always @(negedge clk) begin
    start_t s;
    done_t  d;
    if (resetn) begin
      if (gen_start) begin
        check("start_expected", 64'(exp_start.size() != 0), 64'd1);
        if (exp_start.size() != 0) begin
          s = exp_start.pop_front();
          check("start_entry", 64'(cur_entry), 64'(s.entry));
          check("start_count", 64'(gen_packet_count), 64'(s.count));
          check("start_len", 64'(gen_packet_length), 64'(s.len));
          check("start_idle", 64'(gen_idle_cycles), 64'(s.idle));
          check("start_init", 64'(gen_initial_value), 64'(s.init));
          check("start_timing", 64'(cyc - (s.from_run ? run_cyc : fall_cyc)), 64'(s.delay));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_expected", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          check("done_bursts", 64'(bursts_done), 64'(d.bursts));
          if (d.loop >= 0) check("done_loop", 64'(cur_loop), 64'(d.loop));
          check("done_running", 64'(running), 64'd0);
          check("done_timing", 64'(cyc - (d.from_run ? run_cyc : fall_cyc)), 64'(d.delay));
        end
      end
    end
    prev_busy <= gen_busy;
    if (prev_busy && !gen_busy) fall_cyc <= cyc;
  end

  task automatic wr(input int a, input logic [31:0] c, input logic [15:0] l,
                    input logic [15:0] i, input logic [15:0] v, input bit upd);
    @(negedge clk);
    tbl_wr    = 1'b1;
    tbl_addr  = a[AW-1:0];
    tbl_wdata = {v, i, l, c};
    if (upd) tbl_m[a] = {v, i, l, c};
    @(negedge clk);
    tbl_wr = 1'b0;
  endtask

  task automatic push_start(input int e, input bit fr, input int dly);
    start_t s;
    s.entry = e; s.count = tbl_m[e][31:0]; s.len = tbl_m[e][47:32];
    s.idle = tbl_m[e][63:48]; s.init = tbl_m[e][79:64];
    s.from_run = fr; s.delay = dly;
    exp_start.push_back(s);
  endtask

  task automatic push_done(input logic [31:0] b, input int lp, input bit fr, input int dly);
    done_t d;
    d.bursts = b; d.loop = lp; d.from_run = fr; d.delay = dly;
    exp_done.push_back(d);
  endtask

  task automatic pulse_run(input int n, input int lp, input int gap);
    @(negedge clk);
    num_entries = n[AW:0];
    loops       = lp[15:0];
    burst_gap   = gap[15:0];
    run         = 1'b1;
    run_cyc     = cyc;
    @(negedge clk);
    run = 1'b0;
  endtask

  // Queue the whole run (finite loops) from the table model, then launch it.
  task automatic expect_run(input int n, input int lp, input int gap);
    int skips;
    bit first;
    skips = 0;
    first = 1'b1;
    for (int l = 0; l < lp; l++) begin
      for (int e = 0; e < n; e++) begin
        if (tbl_m[e][31:0] == 32'd0) begin
          skips++;
        end else begin
          push_start(e, first, first ? 2 + skips : gap + 2 + skips);
          first = 1'b0;
          skips = 0;
          exp_bursts = exp_bursts + 32'd1;
        end
      end
    end
    push_done(exp_bursts, lp, 1'b0, gap + 1 + skips);
    pulse_run(n, lp, gap);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done_cnt != base), 64'd1);
    repeat (10) @(negedge clk);
    check("start_queue_empty", 64'(exp_start.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done.size()), 64'd0);
  endtask

  task automatic wait_entry_busy(input int e, input int budget);
    int k;
    k = 0;
    while (!(cur_entry == e[AW-1:0] && gen_busy && !gen_start) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("reach_entry_busy", 64'(k < budget), 64'd1);
  endtask

  initial begin
    resetn = 1'b0; tbl_wr = 1'b0; tbl_addr = '0; tbl_wdata = 80'd0;
    num_entries = '0; loops = 16'd0; burst_gap = 16'd0; run = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gen_start", 64'(gen_start), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_cur_entry", 64'(cur_entry), 64'd0);
    check("rst_cur_loop", 64'(cur_loop), 64'd0);
    check("rst_bursts", 64'(bursts_done), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_gen_count", 64'(gen_packet_count), 64'd0);
    check("rst_gen_init", 64'(gen_initial_value), 64'd0);
    resetn = 1'b1;

    // Single entry, one pass.
    wr(0, 32'd3, 16'd64, 16'd0, 16'h0010, 1'b1);
    expect_run(1, 1, 0);
    wait_done(200);

    // Three entries, two passes, gap of 5; an in-run write to entry 0 must be dropped.
    wr(0, 32'd1, 16'd128, 16'd2, 16'h00A0, 1'b1);
    wr(1, 32'd2, 16'd256, 16'd3, 16'h00B0, 1'b1);
    wr(2, 32'd1, 16'd1500, 16'd4, 16'h00C0, 1'b1);
    expect_run(3, 2, 5);
    repeat (5) @(negedge clk);
    wr(0, 32'd9, 16'd999, 16'd9, 16'hDEAD, 1'b0);
    wait_done(400);

    // Entry 1 skipped (zero packet count); entry 0 still holds pre-run data.
    wr(1, 32'd0, 16'd77, 16'd1, 16'h00D0, 1'b1);
    expect_run(3, 1, 0);
    wait_done(200);

    // Empty run: done only, no start, counters unchanged.
    push_done(exp_bursts, -1, 1'b1, 1);
    pulse_run(0, 1, 0);
    wait_done(50);

    // Infinite loops, abort during entry 1's long burst.
    wr(0, 32'd2, 16'd60, 16'd0, 16'h0101, 1'b1);
    wr(1, 32'd40, 16'd61, 16'd0, 16'h0202, 1'b1);
    wr(2, 32'd2, 16'd62, 16'd0, 16'h0303, 1'b1);
    push_start(0, 1'b1, 2);
    push_start(1, 1'b0, 2);
    exp_bursts = exp_bursts + 32'd2;
    push_done(exp_bursts, 0, 1'b0, 1);
    pulse_run(3, 0, 0);
    wait_entry_busy(1, 200);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(200);
    check("abort_idle", 64'(running), 64'd0);

    // Reset during WAIT, then a fresh run restarts at entry 0.
    push_start(0, 1'b1, 2);
    push_start(1, 1'b0, 2);
    pulse_run(3, 1, 0);
    wait_entry_busy(1, 200);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_running", 64'(running), 64'd0);
    check("mid_rst_gen_start", 64'(gen_start), 64'd0);
    check("mid_rst_bursts", 64'(bursts_done), 64'd0);
    check("mid_rst_cur_entry", 64'(cur_entry), 64'd0);
    check("mid_rst_cur_loop", 64'(cur_loop), 64'd0);
    check("mid_rst_start_queue", 64'(exp_start.size()), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_bursts = 32'd0;
    expect_run(3, 1, 0);
    wait_done(300);
    check("final_bursts", 64'(bursts_done), 64'(exp_bursts));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
